// File: rtl/mem0_line_ctrl.sv
// mem0_line_ctrl
// Line-level controller between the AXI-to-memory packing buffer and port 1
// of SRAM mem0. It counts the AXI beat strobes that the buffer also sees.
// In write mode it issues one 128-bit SRAM write after every fourth beat.
// In read mode it issues one SRAM read on the first beat of each line.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   start_i, mode_i            launch pulse (IDLE only); 0 = write, 1 = read
//   base_addr_i, num_lines_i   first line address and line count, taken with start_i
//   AXI_write_req/read_req     beat strobes shared with the packing buffer
//   MEM_wdata_i / mem0_d1      packed line from the buffer, passed through to the SRAM
//   mem0_q1 / MEM_rdata_o      SRAM read data, passed through to the buffer
//   mem0_addr1/ce1/we1         SRAM port-1 control
//   busy_o, done_o, err_o      status: transfer active, completion pulse, illegal-beat pulse
//
// state  | meaning
// IDLE   | waiting for start_i; any beat is illegal
// WRITE  | counting write beats, one SRAM write per 4 beats
// READ   | counting read beats, one SRAM read on beat 0 of each line
// DONE   | one-cycle completion pulse; any beat is illegal
module mem0_line_ctrl #(
  parameter int AXI_DATA_WIDTH  = 32,
  parameter int MEM_DATA_WIDTH  = 128,
  parameter int MEM0_ADDR_WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic                       mode_i,
  input  logic [MEM0_ADDR_WIDTH-1:0] base_addr_i,
  input  logic [MEM0_ADDR_WIDTH-1:0] num_lines_i,
  input  logic                       AXI_write_req,
  input  logic                       AXI_read_req,
  input  logic [MEM_DATA_WIDTH-1:0]  MEM_wdata_i,
  input  logic [MEM_DATA_WIDTH-1:0]  mem0_q1,
  output logic [MEM_DATA_WIDTH-1:0]  MEM_rdata_o,
  output logic [MEM0_ADDR_WIDTH-1:0] mem0_addr1,
  output logic                       mem0_ce1,
  output logic                       mem0_we1,
  output logic [MEM_DATA_WIDTH-1:0]  mem0_d1,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o
);

  // The 2-bit beat counter assumes exactly four beats per line.
  if (MEM_DATA_WIDTH != 4 * AXI_DATA_WIDTH) begin : g_width_check
    $error("mem0_line_ctrl: MEM_DATA_WIDTH must equal 4*AXI_DATA_WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [MEM0_ADDR_WIDTH-1:0] ONE = MEM0_ADDR_WIDTH'(1);

  state_t                     state, state_nxt;
  logic [MEM0_ADDR_WIDTH-1:0] addr_cnt, addr_cnt_nxt;
  logic [MEM0_ADDR_WIDTH-1:0] lines_left, lines_left_nxt;
  logic [1:0]                 beat_cnt, beat_cnt_nxt;
  logic                       wr_hit_q, wr_hit_nxt;
  logic                       err_q, err_nxt;
  logic                       read_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      addr_cnt   <= '0;
      lines_left <= '0;
      beat_cnt   <= '0;
      wr_hit_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_nxt;
      addr_cnt   <= addr_cnt_nxt;
      lines_left <= lines_left_nxt;
      beat_cnt   <= beat_cnt_nxt;
      wr_hit_q   <= wr_hit_nxt;
      err_q      <= err_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    addr_cnt_nxt   = addr_cnt;
    lines_left_nxt = lines_left;
    beat_cnt_nxt   = beat_cnt;
    wr_hit_nxt     = 1'b0;
    err_nxt        = 1'b0;
    read_hit       = 1'b0;

    case (state)
      S_IDLE: begin
        err_nxt = AXI_write_req | AXI_read_req;
        if (start_i) begin
          addr_cnt_nxt   = base_addr_i;
          lines_left_nxt = num_lines_i;
          beat_cnt_nxt   = '0;
          if (num_lines_i == '0) state_nxt = S_DONE;
          else if (mode_i)       state_nxt = S_READ;
          else                   state_nxt = S_WRITE;
        end
      end

      S_WRITE: begin
        err_nxt = AXI_read_req;
        if (AXI_write_req) begin
          beat_cnt_nxt = beat_cnt + 2'd1;
          // The buffer holds the full line only after the 4th beat's edge,
          // so the SRAM write is issued one cycle later.
          wr_hit_nxt   = (beat_cnt == 2'd3);
        end
        if (wr_hit_q) begin
          addr_cnt_nxt   = addr_cnt + ONE;
          lines_left_nxt = lines_left - ONE;
          if (lines_left == ONE) state_nxt = S_DONE;
        end
      end

      S_READ: begin
        err_nxt = AXI_write_req;
        if (AXI_read_req) begin
          // Address goes out in the same cycle so q1 is valid when the
          // buffer samples on its delayed read strobe.
          read_hit     = (beat_cnt == 2'd0);
          beat_cnt_nxt = beat_cnt + 2'd1;
          if (beat_cnt == 2'd3) begin
            addr_cnt_nxt   = addr_cnt + ONE;
            lines_left_nxt = lines_left - ONE;
            if (lines_left == ONE) state_nxt = S_DONE;
          end
        end
      end

      S_DONE: begin
        err_nxt   = AXI_write_req | AXI_read_req;
        state_nxt = S_IDLE;
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  assign mem0_ce1    = wr_hit_q | read_hit;
  assign mem0_we1    = wr_hit_q;
  assign mem0_addr1  = addr_cnt;
  assign mem0_d1     = MEM_wdata_i;
  assign MEM_rdata_o = mem0_q1;
  assign busy_o      = (state == S_WRITE) || (state == S_READ);
  assign done_o      = (state == S_DONE);
  assign err_o       = err_q;

endmodule

// File: tb/tb_mem0_line_ctrl.sv
// Testbench for mem0_line_ctrl: a table of directed vectors for a 2-line
// write, hand-written corner sequences, and random traffic.
// A transfer-level reference model runs alongside and checks every cycle.
module tb_mem0_line_ctrl;
  logic         clk = 1'b0;
  logic         rst;
  logic         start_i, mode_i;
  logic [9:0]   base_addr_i, num_lines_i;
  logic         AXI_write_req, AXI_read_req;
  logic [127:0] MEM_wdata_i, mem0_q1, MEM_rdata_o, mem0_d1;
  logic [9:0]   mem0_addr1;
  logic         mem0_ce1, mem0_we1, busy_o, done_o, err_o;

  mem0_line_ctrl #(.AXI_DATA_WIDTH(32), .MEM_DATA_WIDTH(128), .MEM0_ADDR_WIDTH(10)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .mode_i(mode_i),
    .base_addr_i(base_addr_i), .num_lines_i(num_lines_i),
    .AXI_write_req(AXI_write_req), .AXI_read_req(AXI_read_req),
    .MEM_wdata_i(MEM_wdata_i), .mem0_q1(mem0_q1), .MEM_rdata_o(MEM_rdata_o),
    .mem0_addr1(mem0_addr1), .mem0_ce1(mem0_ce1), .mem0_we1(mem0_we1),
    .mem0_d1(mem0_d1), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model in transfer terms.
  // phase: 0 idle, 1 transferring, 2 done.
  int m_phase, m_base, m_nlines, m_beats, m_lines_wr, m_pend;
  bit m_mode, m_err;

  logic [10:0] ce_log[$];  // {we, addr} of every SRAM access seen
  int n_done, n_err;

  typedef struct {
    logic       start, mode;
    logic [9:0] base, n;
    logic       wr, rd;
    logic [14:0] exp;  // {ce, we, addr, busy, done, err}
  } vec_t;

  vec_t tab[15];

  function automatic vec_t mk(logic s, logic m, logic [9:0] b, logic [9:0] n, logic w, logic r,
                              logic ce, logic we, logic [9:0] a, logic bz, logic dn, logic er);
    vec_t v;
    v.start = s; v.mode = m; v.base = b; v.n = n; v.wr = w; v.rd = r;
    v.exp = {ce, we, a, bz, dn, er};
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_base = 0; m_nlines = 0; m_beats = 0; m_lines_wr = 0;
    m_pend = -1; m_mode = 0; m_err = 0;
  endtask

  task automatic model_expect(output logic [14:0] e);
    logic ce, we;
    logic [9:0] a;
    int t;
    ce = 0; we = 0; a = '0;
    if (m_pend >= 0) begin
      ce = 1; we = 1; a = m_pend[9:0];
    end else if (m_phase == 1 && m_mode && AXI_read_req && (m_beats % 4) == 0) begin
      ce = 1;
      t = (m_base + m_beats / 4) % 1024;
      a = t[9:0];
    end
    e = {ce, we, a, m_phase == 1, m_phase == 2, m_err};
  endtask

  task automatic model_step();
    int ph, new_pend;
    bit new_err;
    if (rst) begin
      model_reset();
      return;
    end
    ph = m_phase; new_err = 0; new_pend = -1;
    case (ph)
      0: begin
        new_err = AXI_write_req | AXI_read_req;
        if (start_i) begin
          m_base = base_addr_i; m_nlines = num_lines_i; m_mode = mode_i;
          m_beats = 0; m_lines_wr = 0;
          m_phase = (num_lines_i == 0) ? 2 : 1;
        end
      end
      1: begin
        if (!m_mode) begin
          new_err = AXI_read_req;
          if (m_pend >= 0) m_lines_wr++;
          if (AXI_write_req) begin
            m_beats++;
            if (m_beats % 4 == 0) new_pend = (m_base + m_beats / 4 - 1) % 1024;
          end
          if (m_pend >= 0 && m_lines_wr == m_nlines) m_phase = 2;
        end else begin
          new_err = AXI_write_req;
          if (AXI_read_req) begin
            m_beats++;
            if (m_beats == 4 * m_nlines) m_phase = 2;
          end
        end
      end
      default: begin
        new_err = AXI_write_req | AXI_read_req;
        m_phase = 0;
      end
    endcase
    m_err = new_err;
    m_pend = new_pend;
  endtask

  task automatic drive(input logic s, input logic m, input logic [9:0] b, input logic [9:0] n,
                       input logic w, input logic r);
    start_i = s; mode_i = m; base_addr_i = b; num_lines_i = n;
    AXI_write_req = w; AXI_read_req = r;
    MEM_wdata_i = {$urandom, $urandom, $urandom, $urandom};
    mem0_q1     = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // One clock cycle: compare mid-cycle, advance the model, then move past the edge.
  task automatic cyc(input bit use_tab, input logic [14:0] tab_exp, input string tag);
    logic [14:0] e;
    logic [16:0] act;
    @(negedge clk);
    model_expect(e);
    act = {mem0_ce1, mem0_we1, (mem0_ce1 ? mem0_addr1 : 10'd0), busy_o, done_o, err_o,
           (MEM_rdata_o === mem0_q1), (mem0_d1 === MEM_wdata_i)};
    check("model", act, {e, 2'b11});
    if (use_tab) check(tag, act[16:2], tab_exp);
    if (mem0_ce1) ce_log.push_back({mem0_we1, mem0_addr1});
    if (done_o) n_done++;
    if (err_o) n_err++;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic s, input logic m, input logic [9:0] b, input logic [9:0] n,
                      input logic w, input logic r);
    drive(s, m, b, n, w, r);
    cyc(1'b0, '0, "");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic clear_logs();
    ce_log.delete();
    n_done = 0;
    n_err = 0;
  endtask

  initial begin
    logic [9:0] exp_a[3];
    logic [9:0] b, n;
    logic w, r, s;

    model_reset();
    clear_logs();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    cyc(1'b0, '0, "");
    cyc(1'b0, '0, "");
    rst = 1'b0;

    // Two-line write at 0x010 with back-to-back beats, then a stray beat in IDLE.
    tab[0]  = mk(1, 0, 10'h010, 10'd2, 0, 0, 0, 0, 10'h000, 0, 0, 0);
    tab[1]  = mk(0, 0, 10'h000, 10'd0, 1, 0, 0, 0, 10'h000, 1, 0, 0);
    tab[2]  = mk(0, 0, 10'h000, 10'd0, 1, 0, 0, 0, 10'h000, 1, 0, 0);
    tab[3]  = mk(0, 0, 10'h000, 10'd0, 1, 0, 0, 0, 10'h000, 1, 0, 0);
    tab[4]  = mk(0, 0, 10'h000, 10'd0, 1, 0, 0, 0, 10'h000, 1, 0, 0);
    tab[5]  = mk(0, 0, 10'h000, 10'd0, 1, 0, 1, 1, 10'h010, 1, 0, 0);
    tab[6]  = mk(0, 0, 10'h000, 10'd0, 1, 0, 0, 0, 10'h000, 1, 0, 0);
    tab[7]  = mk(0, 0, 10'h000, 10'd0, 1, 0, 0, 0, 10'h000, 1, 0, 0);
    tab[8]  = mk(0, 0, 10'h000, 10'd0, 1, 0, 0, 0, 10'h000, 1, 0, 0);
    tab[9]  = mk(0, 0, 10'h000, 10'd0, 0, 0, 1, 1, 10'h011, 1, 0, 0);
    tab[10] = mk(0, 0, 10'h000, 10'd0, 0, 0, 0, 0, 10'h000, 0, 1, 0);
    tab[11] = mk(0, 0, 10'h000, 10'd0, 0, 0, 0, 0, 10'h000, 0, 0, 0);
    tab[12] = mk(0, 0, 10'h000, 10'd0, 1, 0, 0, 0, 10'h000, 0, 0, 0);
    tab[13] = mk(0, 0, 10'h000, 10'd0, 0, 0, 0, 0, 10'h000, 0, 0, 1);
    tab[14] = mk(0, 0, 10'h000, 10'd0, 0, 0, 0, 0, 10'h000, 0, 0, 0);
    for (int i = 0; i < 15; i++) begin
      drive(tab[i].start, tab[i].mode, tab[i].base, tab[i].n, tab[i].wr, tab[i].rd);
      cyc(1'b1, tab[i].exp, $sformatf("vec%0d", i));
    end

    // Read 3 lines at 0x3FE: the address wraps to 0x000.
    clear_logs();
    step(1, 1, 10'h3FE, 10'd3, 0, 0);
    for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 0, 1);
    idle(3);
    exp_a[0] = 10'h3FE; exp_a[1] = 10'h3FF; exp_a[2] = 10'h000;
    check("rd_wrap_count", ce_log.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < ce_log.size()) check($sformatf("rd_wrap_addr%0d", i), ce_log[i], {1'b0, exp_a[i]});
    check("rd_wrap_done", n_done, 1);

    // Zero lines: done pulse, no SRAM access.
    clear_logs();
    step(1, 0, 10'h123, 10'd0, 0, 0);
    idle(3);
    check("zero_lines_access", ce_log.size(), 0);
    check("zero_lines_done", n_done, 1);

    // Read beat during WRITE is flagged and does not advance the beat count.
    clear_logs();
    step(1, 0, 10'h033, 10'd1, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    idle(3);
    check("illegal_rd_err", n_err, 1);
    check("illegal_rd_count", ce_log.size(), 1);
    if (ce_log.size() > 0) check("illegal_rd_write", ce_log[0], {1'b1, 10'h033});

    // Reset after 2 beats, then a fresh 1-line write at 0x005 needs 4 new beats.
    clear_logs();
    step(1, 0, 10'h020, 10'd1, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    rst = 1'b1;
    step(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    step(1, 0, 10'h005, 10'd1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0);
    idle(2);
    check("rst_no_early_write", ce_log.size(), 0);
    step(0, 0, 0, 0, 1, 0);
    idle(3);
    check("rst_write_count", ce_log.size(), 1);
    if (ce_log.size() > 0) check("rst_write_addr", ce_log[0], {1'b1, 10'h005});

    // start_i during an active READ is ignored.
    clear_logs();
    step(1, 1, 10'h100, 10'd2, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1);
    step(1, 0, 10'h200, 10'd1, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1);
    idle(3);
    check("restart_count", ce_log.size(), 2);
    if (ce_log.size() > 1) begin
      check("restart_addr0", ce_log[0], {1'b0, 10'h100});
      check("restart_addr1", ce_log[1], {1'b0, 10'h101});
    end
    check("restart_done", n_done, 1);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      s = (m_phase == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 29) == 0);
      b = ($urandom_range(0, 3) == 0) ? 10'(1020 + $urandom_range(0, 3)) : 10'($urandom_range(0, 1023));
      n = 10'($urandom_range(0, 3));
      if (m_phase == 1 && !m_mode) begin
        w = ($urandom_range(0, 9) < 7); r = ($urandom_range(0, 19) == 0);
      end else if (m_phase == 1) begin
        r = ($urandom_range(0, 9) < 7); w = ($urandom_range(0, 19) == 0);
      end else begin
        w = ($urandom_range(0, 9) == 0); r = ($urandom_range(0, 9) == 0);
      end
      rst = ($urandom_range(0, 299) == 0);
      step(s, logic'($urandom_range(0, 1)), b, n, w, r);
    end
    rst = 1'b0;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem0_line_ctrl.md
# mem0_line_ctrl

Line-level controller between the AXI-to-memory packing buffer and port 1 of on-chip SRAM mem0. It counts the 32-bit AXI beat strobes the buffer also sees and issues one 128-bit SRAM write after every fourth write beat. On the first read beat of each line it issues one SRAM read, timed so the buffer captures the line on its delayed read strobe. Transfers are programmed as base address plus line count; the block reports busy, done and protocol errors.

## Interface
- AXI_DATA_WIDTH, 32: width of one AXI beat.
- MEM_DATA_WIDTH, 128: SRAM line width; must equal 4*AXI_DATA_WIDTH.
- MEM0_ADDR_WIDTH, 10: SRAM line-address width.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  one-cycle pulse that launches a transfer; sampled only in IDLE.
- mode_i  in  1  0 = write (AXI→SRAM), 1 = read (SRAM→AXI); sampled with start_i.
- base_addr_i  in  MEM0_ADDR_WIDTH  first line address; sampled with start_i.
- num_lines_i  in  MEM0_ADDR_WIDTH  number of 128-bit lines; sampled with start_i.
- AXI_write_req  in  1  write-beat strobe, shared with the packing buffer.
- AXI_read_req  in  1  read-beat strobe, shared with the packing buffer.
- MEM_wdata_i  in  MEM_DATA_WIDTH  packed line from the buffer.
- mem0_q1  in  MEM_DATA_WIDTH  SRAM read data; 1-cycle read latency.
- MEM_rdata_o  out  MEM_DATA_WIDTH  line to the buffer; combinational copy of mem0_q1.
- mem0_addr1  out  MEM0_ADDR_WIDTH  SRAM address.
- mem0_ce1  out  1  SRAM chip enable.
- mem0_we1  out  1  SRAM write enable.
- mem0_d1  out  MEM_DATA_WIDTH  SRAM write data; combinational copy of MEM_wdata_i.
- busy_o  out  1  high in WRITE or READ.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  one-cycle pulse on an illegal beat.

## Operation
- States: IDLE, WRITE, READ, DONE. Registers: addr_cnt (MEM0_ADDR_WIDTH), lines_left (MEM0_ADDR_WIDTH), beat_cnt (2 bits), wr_hit_q (1 bit).
- IDLE + start_i:
  - Load addr_cnt=base_addr_i, lines_left=num_lines_i, beat_cnt=0.
  - If num_lines_i==0, go to DONE. Otherwise go to WRITE (mode_i=0) or READ (mode_i=1).
  - start_i outside IDLE is ignored.
- WRITE:
  - Each AXI_write_req increments beat_cnt, wrapping 3→0.
  - wr_hit_q <= AXI_write_req && beat_cnt==3.
  - While wr_hit_q=1: mem0_ce1=1, mem0_we1=1, mem0_addr1=addr_cnt. At that edge addr_cnt+1 and lines_left−1.
  - When lines_left goes 1→0 on a write hit, go to DONE.
- READ:
  - read_hit = AXI_read_req && beat_cnt==0, combinational. It drives mem0_ce1=1, mem0_we1=0, mem0_addr1=addr_cnt.
  - Each AXI_read_req increments beat_cnt.
  - On a beat with beat_cnt==3: addr_cnt+1 and lines_left−1. Go to DONE if lines_left was 1.
- DONE: done_o=1 for exactly one cycle, then IDLE.
- mem0_ce1 = wr_hit_q || read_hit. mem0_we1 = wr_hit_q.
- Address arithmetic is modulo 2^MEM0_ADDR_WIDTH; 1023+1 wraps to 0 with no flag.
- Illegal beats pulse err_o the next cycle, and the beat is otherwise ignored (no counter change):
  - any beat in IDLE or DONE;
  - AXI_read_req in WRITE;
  - AXI_write_req in READ.
- Both strobes in the same cycle: the strobe matching the current mode is processed; the other pulses err_o.

## Timing
- Reset values: mem0_addr1=0, mem0_ce1=0, mem0_we1=0, busy_o=0, done_o=0, err_o=0; state=IDLE; all counters 0. MEM_rdata_o and mem0_d1 follow their inputs.
- rst asserted mid-transfer aborts within one edge. No SRAM access is issued in the cycle after rst.
- Write latency: 4th beat at edge N. The buffer holds the full line after edge N, and the SRAM write occurs at edge N+1 (wr_hit_q high during cycle N..N+1).
- Read latency: first beat of a line in cycle N drives the SRAM address in the same cycle. mem0_q1 is valid in cycle N+1, when the buffer samples on its delayed read strobe.
- busy_o is high from the cycle after start_i until the cycle DONE is entered. A 1-line write ends with done_o one cycle after the SRAM write cycle.
- Back-to-back beats every cycle must be sustained with no stall.

## Test plan
- Write 2 lines at base 0x010, 8 consecutive write beats → SRAM writes at 0x010 then 0x011, one cycle after beats 4 and 8; done_o follows; busy_o low afterwards.
- Read 3 lines at base 0x3FE, 12 read beats → mem0_ce1 with we1=0 at 0x3FE, 0x3FF, 0x000 on beats 1, 5, 9; MEM_rdata_o equals mem0_q1 in the following cycles.
- start_i with num_lines_i=0 → DONE next cycle, done_o pulse, no mem0_ce1 ever.
- AXI_write_req in IDLE, and AXI_read_req during WRITE → err_o one-cycle pulse each; beat_cnt and addr_cnt unchanged.
- Assert rst after 2 beats of a write line → IDLE, no SRAM write. A new 1-line write at 0x005 then writes only after 4 fresh beats.
- start_i during an active READ → ignored; the transfer completes with the original address and count.
